// File: rtl/clk_div_ctrl_if.sv
// clk_div_ctrl_if: divisor-change request channel of the clock-divider controller.
// Signals: cfg_valid/cfg_div from the config master; cfg_ready/cfg_err back from the controller.
interface clk_div_ctrl_if #(
    parameter int WIDTH = 16
) ();
    logic             cfg_valid;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time programmable, glitch-free clock divider controller.
// Ports: clk_in, rst (async active-low), en, cfg (slave: valid/div/ready/err),
//        clk_out, tick, busy, div_active; tick_count only with CLK_DIV_CTRL_TICK_CNT_EN.
module clk_div_ctrl #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 10,
    parameter int MIN_DIV     = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    clk_div_ctrl_if.slave    cfg,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic [WIDTH-1:0] div_active
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
    ,
    output logic [15:0]      tick_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_pend;
    logic [WIDTH-1:0] next_cnt;
    logic [WIDTH-1:0] commit_div;
    logic             err_q;
    logic             accept;
    logic             req_ok;
    logic             wrap;

    assign cfg.cfg_ready = rst & (state != PEND);
    assign cfg.cfg_err   = err_q;
    assign busy          = (state == PEND);

    // commit_div is the divisor the next period uses when a boundary
    // (IDLE or wrap) is taken this cycle: a held pending value wins,
    // otherwise a valid request arriving right now, otherwise unchanged.
    always_comb begin
        accept     = cfg.cfg_valid & cfg.cfg_ready;
        req_ok     = (cfg.cfg_div >= WIDTH'(MIN_DIV));
        wrap       = (cnt == div_active - WIDTH'(1));
        next_cnt   = wrap ? '0 : cnt + WIDTH'(1);
        commit_div = div_active;
        if (state == PEND) begin
            commit_div = div_pend;
        end else if (accept && req_ok) begin
            commit_div = cfg.cfg_div;
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            div_active <= WIDTH'(DEFAULT_DIV);
            div_pend   <= '0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= accept & ~req_ok;
            case (state)
                IDLE: begin
                    cnt        <= '0;
                    div_active <= commit_div;
                    clk_out    <= en && ((commit_div >> 1) != '0);
                    tick       <= en;
                    if (en) state <= RUN;
                end
                default: begin
                    if (wrap) begin
                        // Period boundary: the only point where the
                        // divisor and run/stop may change.
                        cnt        <= '0;
                        div_active <= commit_div;
                        clk_out    <= en && ((commit_div >> 1) != '0);
                        tick       <= en;
                        state      <= en ? RUN : IDLE;
                    end else begin
                        cnt     <= next_cnt;
                        clk_out <= (next_cnt < (div_active >> 1));
                        tick    <= 1'b0;
                        if (state == RUN && accept && req_ok) begin
                            div_pend <= cfg.cfg_div;
                            state    <= PEND;
                        end
                    end
                end
            endcase
        end
    end

`ifdef CLK_DIV_CTRL_TICK_CNT_EN
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            tick_count <= '0;
        end else if (tick) begin
            tick_count <= tick_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: scoreboard bench for clk_div_ctrl.
// Stimulus queues one expected record per tick; a monitor checks period/high/divisor.
module tb_clk_div_ctrl;

    localparam int W = 16;

    logic         clk_in = 1'b0;
    logic         rst    = 1'b0;
    logic         en     = 1'b0;
    logic         clk_out;
    logic         tick;
    logic         busy;
    logic [W-1:0] div_active;
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
    logic [15:0]  tick_count;
`endif

    clk_div_ctrl_if #(.WIDTH(W)) cfg ();

    clk_div_ctrl #(
        .WIDTH       (W),
        .DEFAULT_DIV (10),
        .MIN_DIV     (2)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .en         (en),
        .cfg        (cfg),
        .clk_out    (clk_out),
        .tick       (tick),
        .busy       (busy),
        .div_active (div_active)
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
        ,
        .tick_count (tick_count)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int len;
        int high;
        int div;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(int len, int high, int div);
        exp_t e;
        e.len  = len;
        e.high = high;
        e.div  = div;
        q.push_back(e);
    endtask

    task automatic wt(output int n);
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!tick && n < 200);
        if (!tick) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: got no tick expected one within 200 cycles");
        end
    endtask

    task automatic wt1();
        int n;
        wt(n);
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Monitor: measures each completed period and checks it at the next tick.
    initial begin
        int   len;
        int   high;
        exp_t e;
        len  = 0;
        high = 0;
        forever begin
            @(negedge clk_in);
            if (!rst) begin
                len  = 0;
                high = 0;
            end else if (tick) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tick: got tick expected none");
                end else begin
                    e = q.pop_front();
                    chk("tick_div", 32'(div_active), e.div);
                    if (e.len != 0) begin
                        chk("period", len, e.len);
                        chk("high_time", high, e.high);
                    end
                end
                len  = 1;
                high = clk_out ? 1 : 0;
            end else begin
                len++;
                high += clk_out ? 1 : 0;
            end
        end
    end

    initial begin
        int n;
        int h;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_div   = '0;

        // Reset state
        repeat (2) @(negedge clk_in);
        chk("rst_clk_out", 32'(clk_out), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_div", 32'(div_active), 10);
        chk("rst_ready", 32'(cfg.cfg_ready), 0);
        chk("rst_err", 32'(cfg.cfg_err), 0);
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
        chk("rst_tick_count", 32'(tick_count), 0);
`endif
        cyc(1);
        rst = 1'b1;
        @(negedge clk_in);
        chk("idle_ready", 32'(cfg.cfg_ready), 1);
        chk("idle_clk_out", 32'(clk_out), 0);

        // Default divisor 10
        push(0, 0, 10);
        push(10, 5, 10);
        push(10, 5, 10);
        cyc(1);
        en = 1'b1;
        wt(n);
        chk("start_latency", n, 2);
        chk("run_busy", 32'(busy), 0);
        wt1();
        wt1();

        // Change to 4 mid-period
        push(10, 5, 4);
        repeat (3) push(4, 2, 4);
        cyc(2);
        cfg.cfg_valid = 1'b1;
        cfg.cfg_div   = 16'd4;
        cyc(1);
        cfg.cfg_valid = 1'b0;
        @(negedge clk_in);
        chk("pend_busy", 32'(busy), 1);
        chk("pend_ready", 32'(cfg.cfg_ready), 0);
        chk("pend_div", 32'(div_active), 10);
        wt1();
        chk("commit_busy", 32'(busy), 0);
        repeat (3) wt1();

        // Back to 10
        push(4, 2, 10);
        push(10, 5, 10);
        push(10, 5, 10);
        cyc(1);
        cfg.cfg_valid = 1'b1;
        cfg.cfg_div   = 16'd10;
        cyc(1);
        cfg.cfg_valid = 1'b0;
        repeat (3) wt1();

        // Change to 6 exactly at the wrap
        push(10, 5, 6);
        push(6, 3, 6);
        push(6, 3, 6);
        cyc(9);
        cfg.cfg_valid = 1'b1;
        cfg.cfg_div   = 16'd6;
        cyc(1);
        cfg.cfg_valid = 1'b0;
        wt(n);
        chk("wrap_accept_lat", n, 1);
        chk("wrap_accept_busy", 32'(busy), 0);
        wt1();
        wt1();

        // Illegal divisors 1 and 0
        push(6, 3, 6);
        cyc(2);
        cfg.cfg_valid = 1'b1;
        cfg.cfg_div   = 16'd1;
        cyc(1);
        cfg.cfg_valid = 1'b0;
        @(negedge clk_in);
        chk("err1_pulse", 32'(cfg.cfg_err), 1);
        chk("err1_busy", 32'(busy), 0);
        chk("err1_ready", 32'(cfg.cfg_ready), 1);
        @(negedge clk_in);
        chk("err1_clear", 32'(cfg.cfg_err), 0);
        chk("err1_div", 32'(div_active), 6);
        wt1();
        push(6, 3, 6);
        cyc(2);
        cfg.cfg_valid = 1'b1;
        cfg.cfg_div   = 16'd0;
        cyc(1);
        cfg.cfg_valid = 1'b0;
        @(negedge clk_in);
        chk("err0_pulse", 32'(cfg.cfg_err), 1);
        @(negedge clk_in);
        chk("err0_clear", 32'(cfg.cfg_err), 0);
        wt1();

        // Stop with 8 pending
        cyc(1);
        cfg.cfg_valid = 1'b1;
        cfg.cfg_div   = 16'd8;
        cyc(1);
        cfg.cfg_valid = 1'b0;
        en = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("stop_pend_busy", 32'(busy), 1);
        chk("stop_low_phase", 32'(clk_out), 0);
        @(negedge clk_in);
        chk("stop_clk_out", 32'(clk_out), 0);
        chk("stop_tick", 32'(tick), 0);
        chk("stop_busy", 32'(busy), 0);
        chk("stop_div", 32'(div_active), 8);
        h = 0;
        repeat (5) begin
            @(negedge clk_in);
            h += clk_out ? 1 : 0;
        end
        chk("idle_hold_high", h, 0);
        push(0, 0, 8);
        push(8, 4, 8);
        push(8, 4, 8);
        cyc(1);
        en = 1'b1;
        wt(n);
        chk("restart_latency", n, 2);
        wt1();
        wt1();

        // Reset during the high phase with 3 pending
        cyc(1);
        cfg.cfg_valid = 1'b1;
        cfg.cfg_div   = 16'd3;
        cyc(1);
        cfg.cfg_valid = 1'b0;
        @(negedge clk_in);
        chk("pre_rst_busy", 32'(busy), 1);
        chk("pre_rst_high", 32'(clk_out), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_clk_out", 32'(clk_out), 0);
        chk("mid_rst_tick", 32'(tick), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_div", 32'(div_active), 10);
        chk("mid_rst_ready", 32'(cfg.cfg_ready), 0);
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
        chk("mid_rst_tick_count", 32'(tick_count), 0);
`endif
        push(0, 0, 10);
        repeat (39) push(10, 5, 10);
        cyc(1);
        rst = 1'b1;
        repeat (40) wt1();
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
        @(negedge clk_in);
        chk("tick_count_40", 32'(tick_count), 40);
`endif

        // Stop, program 3 while idle, restart
        cyc(1);
        en = 1'b0;
        cyc(12);
        chk("idle2_ready", 32'(cfg.cfg_ready), 1);
        cfg.cfg_valid = 1'b1;
        cfg.cfg_div   = 16'd3;
        cyc(1);
        cfg.cfg_valid = 1'b0;
        @(negedge clk_in);
        chk("idle_cfg_div", 32'(div_active), 3);
        chk("idle_cfg_clk", 32'(clk_out), 0);
        push(0, 0, 3);
        push(3, 1, 3);
        push(3, 1, 3);
        cyc(1);
        en = 1'b1;
        repeat (3) wt1();

        repeat (2) @(negedge clk_in);
        chk("scoreboard_left", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
